// File: rtl/sludge_pkg.sv
// Shared constants and types for the sludge runner: colours, screen size,
// default geometry/physics and the vertical-motion state type.
package sludge_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_PLAYER_W  = 16;
  localparam int DEF_PLAYER_H  = 24;
  localparam int DEF_GROUND_Y  = 400;
  localparam int DEF_PLAYER_X0 = 312;
  localparam int DEF_X_MAX     = SCREEN_W - DEF_PLAYER_W;
  localparam int DEF_MOVE_STEP = 2;
  localparam int DEF_JUMP_V0   = 12;
  localparam int DEF_GRAVITY   = 1;

  // 12-bit colours packed as {R,G,B}, 4 bits each
  localparam logic [11:0] COL_PLAYER = 12'hF80;
  localparam logic [11:0] COL_FLOOR  = 12'h0A2;
  localparam logic [11:0] COL_SKY    = 12'h248;
  localparam logic [11:0] COL_BLANK  = 12'h000;

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } state_e;

endpackage

// File: rtl/sludge_player_renderer_button_sync.sv
// Two-flop synchronizer for an asynchronous push-button, with a registered
// one-cycle pulse on each synchronized rising edge.
module button_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sludge_player_renderer.sv
// Runner physics (updated once per frame on screenEnd) and a two-stage pixel
// renderer whose colour and sync outputs stay aligned at the DAC.
module sludge_player_renderer
  import sludge_pkg::*;
#(
  parameter int PLAYER_W  = DEF_PLAYER_W,
  parameter int PLAYER_H  = DEF_PLAYER_H,
  parameter int GROUND_Y  = DEF_GROUND_Y,
  parameter int PLAYER_X0 = DEF_PLAYER_X0,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int MOVE_STEP = DEF_MOVE_STEP,
  parameter int JUMP_V0   = DEF_JUMP_V0,
  parameter int GRAVITY   = DEF_GRAVITY
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       active,
  input  logic       screenEnd,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       airborne
);

  localparam logic [9:0]         X0_10    = 10'(PLAYER_X0);
  localparam logic [9:0]         XMAX_10  = 10'(X_MAX);
  localparam logic [9:0]         STEP_10  = 10'(MOVE_STEP);
  localparam logic [9:0]         GY_10    = 10'(GROUND_Y);
  localparam logic [9:0]         FLOOR_10 = 10'(GROUND_Y + PLAYER_H);
  localparam logic [10:0]        PW_11    = 11'(PLAYER_W);
  localparam logic [10:0]        PH_11    = 11'(PLAYER_H);
  localparam logic signed [10:0] GY_S11   = 11'(GROUND_Y);
  localparam logic signed [7:0]  V0_8     = 8'(JUMP_V0);
  localparam logic signed [7:0]  GRAV_8   = 8'(GRAVITY);

  logic left_s, right_s, jump_rise;

  button_sync u_sync_left (
    .clk_i(clk25), .rst_i(reset), .btn_i(btn_left),  .level_o(left_s),  .rise_o()
  );
  button_sync u_sync_right (
    .clk_i(clk25), .rst_i(reset), .btn_i(btn_right), .level_o(right_s), .rise_o()
  );
  button_sync u_sync_jump (
    .clk_i(clk25), .rst_i(reset), .btn_i(btn_jump),  .level_o(),        .rise_o(jump_rise)
  );

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vel_q, vel_d;
  logic              jreq_q, jreq_d;
  logic signed [10:0] ny;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q <= GROUND;
      x_q     <= X0_10;
      y_q     <= GY_10;
      vel_q   <= '0;
      jreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      jreq_q  <= jreq_d;
    end
  end

  assign ny = $signed({1'b0, y_q}) - $signed({{3{vel_q[7]}}, vel_q});

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    // presses while airborne are dropped rather than queued for landing
    jreq_d  = jreq_q | (jump_rise & (state_q == GROUND));

    if (screenEnd) begin
      jreq_d = 1'b0;

      if (left_s && !right_s) begin
        x_d = (x_q < STEP_10) ? 10'd0 : x_q - STEP_10;
      end else if (right_s && !left_s) begin
        x_d = (x_q > XMAX_10 - STEP_10) ? XMAX_10 : x_q + STEP_10;
      end

      unique case (state_q)
        GROUND: begin
          if (jreq_q || jump_rise) begin
            vel_d   = V0_8;
            state_d = AIR;
          end
        end
        AIR: begin
          if (ny >= GY_S11) begin
            y_d     = GY_10;
            vel_d   = '0;
            state_d = GROUND;
          end else if (ny[10]) begin
            y_d   = 10'd0;
            vel_d = vel_q - GRAV_8;
          end else begin
            y_d   = ny[9:0];
            vel_d = vel_q - GRAV_8;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  assign player_x = x_q;
  assign player_y = y_q;
  assign airborne = (state_q == AIR);

  logic hit_player, hit_floor;

  assign hit_player = ({1'b0, pixel_x} >= {1'b0, x_q}) &&
                      ({1'b0, pixel_x} <  ({1'b0, x_q} + PW_11)) &&
                      ({1'b0, pixel_y} >= {1'b0, y_q}) &&
                      ({1'b0, pixel_y} <  ({1'b0, y_q} + PH_11));
  assign hit_floor  = (pixel_y >= FLOOR_10);

  // Stage 1: hit flags and syncs
  logic act_p1_q, player_p1_q, floor_p1_q, hs_p1_q, vs_p1_q;

  always_ff @(posedge clk25) begin
    if (reset) begin
      act_p1_q    <= 1'b0;
      player_p1_q <= 1'b0;
      floor_p1_q  <= 1'b0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
    end else begin
      act_p1_q    <= active;
      player_p1_q <= hit_player;
      floor_p1_q  <= hit_floor;
      hs_p1_q     <= hSync;
      vs_p1_q     <= vSync;
    end
  end

  // Stage 2: colour mux and syncs
  logic [11:0] rgb_p2_q, rgb_p2_d;
  logic        hs_p2_q, vs_p2_q;

  always_comb begin
    rgb_p2_d = COL_SKY;
    if (!act_p1_q)        rgb_p2_d = COL_BLANK;
    else if (player_p1_q) rgb_p2_d = COL_PLAYER;
    else if (floor_p1_q)  rgb_p2_d = COL_FLOOR;
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      rgb_p2_q <= COL_BLANK;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
    end else begin
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign vga_r  = rgb_p2_q[11:8];
  assign vga_g  = rgb_p2_q[7:4];
  assign vga_b  = rgb_p2_q[3:0];
  assign vga_hs = hs_p2_q;
  assign vga_vs = vs_p2_q;

endmodule

// File: tb/tb_sludge_player_renderer.sv
// Directed bench for sludge_player_renderer: render vectors, jump trajectory,
// horizontal clamping, tick/edge coincidence and reset mid-jump.
module tb_sludge_player_renderer;

  logic       clk25 = 1'b0;
  logic       reset, active, screenEnd, hSync, vSync;
  logic [9:0] pixel_x, pixel_y;
  logic       btn_left, btn_right, btn_jump;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs;
  logic [9:0] player_x, player_y;
  logic       airborne;

  always #20 clk25 = ~clk25;

  sludge_player_renderer dut (
    .clk25(clk25), .reset(reset), .active(active), .screenEnd(screenEnd),
    .hSync(hSync), .vSync(vSync), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .player_x(player_x), .player_y(player_y), .airborne(airborne)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        act;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic tick();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    step();
  endtask

  task automatic press_jump();
    btn_jump = 1'b1;
    repeat (4) step();
    btn_jump = 1'b0;
    repeat (4) step();
  endtask

  // Runs ticks until the player lands; optionally presses jump again while airborne.
  task automatic jump_run(input int press_at, output int n, output int ymin, output int first_y);
    n = 0; ymin = 1023; first_y = -1;
    for (int k = 0; k < 40; k++) begin
      if (n == press_at && n > 0) press_jump();
      tick();
      if (airborne) begin
        n++;
        if (n == 2) first_y = player_y;
        if (player_y < ymin) ymin = player_y;
      end else if (n > 0) begin
        break;
      end
    end
  endtask

  int n, ymin, fy;

  initial begin
    reset = 1'b1; active = 1'b1; screenEnd = 1'b0;
    hSync = 1'b0; vSync = 1'b0; pixel_x = 10'd320; pixel_y = 10'd410;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;

    repeat (3) step();
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_x", player_x, 312);
    chk("rst_y", player_y, 400);
    chk("rst_air", airborne, 0);
    reset = 1'b0;
    hSync = 1'b1; vSync = 1'b1;
    repeat (20) step();
    chk("idle_x", player_x, 312);
    chk("idle_y", player_y, 400);

    // render vectors: player box is x 312..327, y 400..423
    vt[0]  = '{1'b1, 10'd320, 10'd410, 1'b1, 1'b1, 12'hF80};
    vt[1]  = '{1'b1, 10'd0,   10'd450, 1'b0, 1'b1, 12'h0A2};
    vt[2]  = '{1'b1, 10'd0,   10'd0,   1'b1, 1'b0, 12'h248};
    vt[3]  = '{1'b0, 10'd700, 10'd10,  1'b0, 1'b0, 12'h000};
    vt[4]  = '{1'b1, 10'd311, 10'd410, 1'b1, 1'b1, 12'h248};
    vt[5]  = '{1'b1, 10'd312, 10'd400, 1'b0, 1'b1, 12'hF80};
    vt[6]  = '{1'b1, 10'd327, 10'd423, 1'b1, 1'b0, 12'hF80};
    vt[7]  = '{1'b1, 10'd328, 10'd410, 1'b0, 1'b0, 12'h248};
    vt[8]  = '{1'b1, 10'd320, 10'd399, 1'b1, 1'b1, 12'h248};
    vt[9]  = '{1'b1, 10'd320, 10'd424, 1'b0, 1'b1, 12'h0A2};
    vt[10] = '{1'b1, 10'd100, 10'd423, 1'b1, 1'b0, 12'h248};
    vt[11] = '{1'b0, 10'd320, 10'd410, 1'b1, 1'b1, 12'h000};

    for (int i = 0; i <= 12; i++) begin
      if (i < 12) begin
        active = vt[i].act; pixel_x = vt[i].px; pixel_y = vt[i].py;
        hSync = vt[i].hs; vSync = vt[i].vs;
      end
      step();
      if (i >= 1) begin
        chk($sformatf("rgb_v%0d", i - 1), {vga_r, vga_g, vga_b}, vt[i-1].rgb);
        chk($sformatf("hs_v%0d", i - 1), vga_hs, vt[i-1].hs);
        chk($sformatf("vs_v%0d", i - 1), vga_vs, vt[i-1].vs);
      end
    end
    hSync = 1'b1; vSync = 1'b1;

    // full jump with a second press near the end of the flight
    press_jump();
    chk("jump_pending_y", player_y, 400);
    jump_run(24, n, ymin, fy);
    chk("jump_ticks", n, 25);
    chk("jump_peak", ymin, 322);
    chk("jump_first_y", fy, 388);
    chk("jump_land_y", player_y, 400);
    tick();
    chk("air_press_dropped", airborne, 0);

    // jump edge in the same cycle as the tick
    btn_jump = 1'b1;
    step(); step();
    step();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    chk("coinc_air", airborne, 1);
    chk("coinc_y", player_y, 400);
    btn_jump = 1'b0;
    step();
    tick();
    chk("coinc_vel12", player_y, 388);
    for (int k = 0; k < 40 && airborne; k++) tick();
    chk("coinc_land", airborne, 0);

    // jump edge one cycle after the tick
    btn_jump = 1'b1;
    step(); step();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    chk("late_not_air", airborne, 0);
    btn_jump = 1'b0;
    repeat (3) step();
    chk("late_still_ground", airborne, 0);
    tick();
    chk("late_consumed", airborne, 1);
    for (int k = 0; k < 40 && airborne; k++) tick();
    chk("late_land_y", player_y, 400);

    // reset mid-jump
    press_jump();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (airborne && player_y < 345) break;
    end
    chk("mid_y_before", (player_y < 345) ? 1 : 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_y", player_y, 400);
    chk("mid_rst_air", airborne, 0);
    chk("mid_rst_x", player_x, 312);
    repeat (4) step();
    press_jump();
    jump_run(0, n, ymin, fy);
    chk("post_rst_ticks", n, 25);
    chk("post_rst_peak", ymin, 322);
    chk("post_rst_first_y", fy, 388);

    // horizontal clamps
    btn_left = 1'b1;
    repeat (4) step();
    tick();
    chk("left_one", player_x, 310);
    repeat (199) tick();
    chk("left_clamp", player_x, 0);
    btn_left = 1'b0; btn_right = 1'b1;
    repeat (4) step();
    tick();
    chk("right_one", player_x, 2);
    repeat (399) tick();
    chk("right_clamp", player_x, 624);
    btn_right = 1'b0; btn_left = 1'b1;
    repeat (4) step();
    repeat (3) tick();
    chk("left_from_max", player_x, 618);
    btn_right = 1'b1;
    repeat (4) step();
    repeat (5) tick();
    chk("both_hold", player_x, 618);
    btn_left = 1'b0; btn_right = 1'b0;
    repeat (4) step();
    repeat (3) tick();
    chk("none_hold", player_x, 618);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sludge_player_renderer.md
# sludge_player_renderer

Downstream consumer of the VGA timing generator. Holds the runner's position and jump state, updating the physics once per frame on `screenEnd`, and produces the 12-bit RGB pixel stream for the player, sludge floor and sky. It delays `hSync`/`vSync` so sync stays aligned with colour at the DAC pins.

## Interface
Parameters:
- `PLAYER_W`, 16: sprite width, pixels.
- `PLAYER_H`, 24: sprite height, pixels.
- `GROUND_Y`, 400: player top row when standing.
- `PLAYER_X0`, 312: reset x of the player's left column.
- `X_MAX`, 624: rightmost legal `player_x` (640 − `PLAYER_W`).
- `MOVE_STEP`, 2: pixels moved per frame.
- `JUMP_V0`, 12: initial upward velocity, pixels/frame.
- `GRAVITY`, 1: velocity decrement per frame.

Ports:
- `clk25` in 1: 25 MHz pixel clock.
- `reset` in 1: reset, **synchronous, active-high**.
- `active` in 1: visible region, from the timing generator.
- `screenEnd` in 1: one-cycle frame tick.
- `hSync`, `vSync` in 1 each: active-low syncs from the timing generator.
- `pixel_x`, `pixel_y` in 10 each: current pixel coordinates.
- `btn_left`, `btn_right`, `btn_jump` in 1 each: asynchronous push-buttons, active-high.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour.
- `vga_hs`, `vga_vs` out 1 each: delayed syncs.
- `player_x`, `player_y` out 10 each: registered position.
- `airborne` out 1: high while in state AIR.

## Operation
- Each button passes through a 2-FF synchronizer. `btn_jump` also gets rising-edge detection, which sets `jump_req`.
- `jump_req` is cleared on every tick. An edge in the same cycle as a tick is consumed by that tick. Jump presses made while AIR are discarded.
- Tick is `screenEnd`. All physics registers change only in tick cycles, so the picture never tears.
- Horizontal motion, independent of state:
  - left only: `x = max(0, x − MOVE_STEP)`.
  - right only: `x = min(X_MAX, x + MOVE_STEP)`.
  - both or neither: hold.
- Vertical motion uses a 2-state FSM (GROUND, AIR) and a signed 8-bit velocity `vel`.
  - GROUND & `jump_req`: `vel = JUMP_V0`, go to AIR; y unchanged this tick.
  - AIR: `ny = y − vel`, computed in 11-bit signed.
    - `ny >= GROUND_Y`: y = `GROUND_Y`, `vel` = 0, go to GROUND.
    - `ny < 0`: y = 0, `vel` decremented normally.
    - otherwise: y = `ny`, `vel = vel − GRAVITY`.
- Render priority, in this order:
  1. `!active`: 0,0,0.
  2. Player box (`x ≤ px < x+PLAYER_W`, `y ≤ py < y+PLAYER_H`): F,8,0.
  3. Floor (`py ≥ GROUND_Y+PLAYER_H`): 0,A,2.
  4. Otherwise sky: 2,4,8.

## Timing
- Render pipeline, 2 cycles:
  - Stage 1 registers the hit flags (active, player, floor) plus `hSync`/`vSync`.
  - Stage 2 registers the colour mux and the syncs.
  - RGB and `vga_hs`/`vga_vs` both lag their inputs by exactly 2 clocks.
- Button to internal use: 2 synchronizer cycles, plus 1 cycle for the edge detect on jump.
- Position outputs change in the cycle after the tick and hold for the whole next frame.
- Reset values:
  - `player_x` = `PLAYER_X0`, `player_y` = `GROUND_Y`, `vel` = 0, state GROUND, `airborne` = 0, `jump_req` = 0.
  - RGB = 0.
  - `vga_hs` = `vga_vs` = 1, and every pipeline sync register = 1.
  - Synchronizers = 0.
- Reset asserted mid-jump: GROUND at `GROUND_Y` on the next edge; no residual velocity.
- Jump trajectory with defaults, jump consumed at tick T:
  - ticks T+1..T+12 rise by 12, 11, …, 1.
  - peak y = 322 at T+12/T+13.
  - descent 1..12 over T+14..T+25.
  - lands at y = 400, GROUND at T+25; 25 ticks airborne in total.

## Structure
- Package `sludge_pkg`:
  - colour constants (`COL_PLAYER`, `COL_FLOOR`, `COL_SKY`, `COL_BLANK`).
  - screen constants 640/480.
  - FSM state type `{GROUND, AIR}`.
  - the default geometry and physics constants, which the parameters reference.
- Sub-module `button_sync`: 2-FF synchronizer plus registered rising-edge pulse output. Instantiated three times; the edge output is left unused for left/right.
- Top holds the physics FSM and the render pipeline.

## Test plan
- Reset: assert `reset` for 3 cycles, then idle for 1 frame. Expect `player_x` = 312, `player_y` = 400, `airborne` = 0, RGB = 0, syncs = 1 until the pipeline fills.
- Pipeline alignment: drive the real timing generator. Expect `vga_hs` equal to `hSync` delayed exactly 2 clocks. Pixel (320,410) → F,8,0; pixel (0,450) → 0,A,2; pixel (0,0) → 2,4,8; `hPos` 700 → 0,0,0.
- Jump: pulse `btn_jump` mid-frame. Expect `airborne` = 1 for 25 ticks, minimum `player_y` = 322, final y = 400. A second press during AIR has no effect.
- Horizontal clamp: hold `btn_left` for 200 frames → `player_x` = 0. Hold `btn_right` for 400 frames → 624. Hold both → no change.
- Tick coincidence: `btn_jump` edge lands in the `screenEnd` cycle → jump starts on that tick (`vel` = 12). An edge one cycle after the tick → consumed at the following tick.
- Reset mid-jump at y = 340 → next cycle y = 400, GROUND; the next jump follows the full 25-tick trajectory.
